// File: rtl/cla_4bits.sv
// 4-bit carry-lookahead adder slice with registered result and valid tag.
// Optional group generate/propagate outputs: define CLA_4BITS_GROUP_PG_EN.
module cla_4bits #(
    parameter int unsigned IN_REG = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       out_valid
`ifdef CLA_4BITS_GROUP_PG_EN
    ,
    output logic       gp,
    output logic       gg
`endif
);

    logic [3:0] a_s;
    logic [3:0] b_s;
    logic       cin_s;
    logic       v_s;

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [3:0] a_q;
            logic [3:0] b_q;
            logic       cin_q;
            logic       v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= 4'd0;
                    b_q   <= 4'd0;
                    cin_q <= 1'b0;
                    v_q   <= 1'b0;
                end else begin
                    a_q   <= a;
                    b_q   <= b;
                    cin_q <= cin;
                    v_q   <= in_valid;
                end
            end

            assign a_s   = a_q;
            assign b_s   = b_q;
            assign cin_s = cin_q;
            assign v_s   = v_q;
        end else begin : g_no_in_reg
            assign a_s   = a;
            assign b_s   = b;
            assign cin_s = cin;
            assign v_s   = in_valid;
        end
    endgenerate

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_s & b_s;
    assign p = a_s ^ b_s;

    // Every carry is a flat sum-of-products of g, p and cin; no carry feeds another.
    assign c[0] = cin_s;
    assign c[1] = g[0]
                | (p[0] & cin_s);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin_s);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_s);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin_s);

    logic [3:0] sum_d;
    logic       cout_d;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       out_valid_q;

    assign sum_d  = p ^ c[3:0];
    assign cout_d = c[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= 4'd0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v_s;
            if (v_s) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

`ifdef CLA_4BITS_GROUP_PG_EN
    logic gp_d;
    logic gg_d;
    logic gp_q;
    logic gg_q;

    assign gp_d = p[3] & p[2] & p[1] & p[0];
    assign gg_d = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gp_q <= 1'b0;
            gg_q <= 1'b0;
        end else if (v_s) begin
            gp_q <= gp_d;
            gg_q <= gg_d;
        end
    end

    assign gp = gp_q;
    assign gg = gg_q;
`endif

endmodule

// File: tb/tb_cla_4bits.sv
// Directed and exhaustive bench for cla_4bits, IN_REG=0 and IN_REG=1 side by side.
// Group P/G outputs are checked when CLA_4BITS_GROUP_PG_EN is defined.
module tb_cla_4bits;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;

    logic [3:0] sum0;
    logic       cout0;
    logic       ov0;
    logic [3:0] sum1;
    logic       cout1;
    logic       ov1;
`ifdef CLA_4BITS_GROUP_PG_EN
    logic       gp0;
    logic       gg0;
    logic       gp1;
    logic       gg1;
`endif

    int checks;
    int failures;

    cla_4bits #(.IN_REG(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum0),
        .cout      (cout0),
        .out_valid (ov0)
`ifdef CLA_4BITS_GROUP_PG_EN
        ,
        .gp        (gp0),
        .gg        (gg0)
`endif
    );

    cla_4bits #(.IN_REG(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum1),
        .cout      (cout1),
        .out_valid (ov1)
`ifdef CLA_4BITS_GROUP_PG_EN
        ,
        .gp        (gp1),
        .gg        (gg1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {out_valid, cout, sum} packed for compact comparison
    function automatic logic [7:0] r0();
        return {2'b00, ov0, cout0, sum0};
    endfunction

    function automatic logic [7:0] r1();
        return {2'b00, ov1, cout1, sum1};
    endfunction

    function automatic logic [7:0] ex(input logic v, input logic c, input logic [3:0] s);
        return {2'b00, v, c, s};
    endfunction

    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic       vc [4];
    logic [3:0] es [4];
    logic       ec [4];
    logic [4:0] sw_exp [512];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);

        va = '{4'd3, 4'd8, 4'd0, 4'd7};
        vb = '{4'd4, 4'd8, 4'd0, 4'd9};
        vc = '{1'b0, 1'b0, 1'b1, 1'b1};
        es = '{4'b0111, 4'b0000, 4'b0001, 4'b0001};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1};

        #12;
        chk("reset_d0", r0(), 8'h00);
        chk("reset_d1", r1(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 11 + 2 + 0 = 13
        drive(1'b1, 4'b1011, 4'b0010, 1'b0);
        tick();
        chk("t1_d0", r0(), ex(1'b1, 1'b0, 4'b1101));
        chk("t1_d1_lat", {7'd0, ov1}, 8'h00);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        chk("t1_d0_hold", r0(), ex(1'b0, 1'b0, 4'b1101));
        chk("t1_d1", r1(), ex(1'b1, 1'b0, 4'b1101));

        // 15 + 15 + 1 = 31
        drive(1'b1, 4'hF, 4'hF, 1'b1);
        tick();
        chk("max_d0", r0(), ex(1'b1, 1'b1, 4'b1111));
`ifdef CLA_4BITS_GROUP_PG_EN
        chk("max_gpgg_d0", {6'd0, gp0, gg0}, 8'h01);
`endif
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        chk("max_d1", r1(), ex(1'b1, 1'b1, 4'b1111));
`ifdef CLA_4BITS_GROUP_PG_EN
        chk("max_gpgg_d1", {6'd0, gp1, gg1}, 8'h01);
`endif

        // full propagate: 10 + 5 + 1 = 16
        drive(1'b1, 4'b1010, 4'b0101, 1'b1);
        tick();
        chk("prop_d0", r0(), ex(1'b1, 1'b1, 4'b0000));
`ifdef CLA_4BITS_GROUP_PG_EN
        chk("prop_gpgg_d0", {6'd0, gp0, gg0}, 8'h02);
`endif
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        chk("prop_d1", r1(), ex(1'b1, 1'b1, 4'b0000));
`ifdef CLA_4BITS_GROUP_PG_EN
        chk("prop_gpgg_d1", {6'd0, gp1, gg1}, 8'h02);
`endif

        // zero boundary
        drive(1'b1, 4'd0, 4'd0, 1'b0);
        tick();
        chk("zero_d0", r0(), ex(1'b1, 1'b0, 4'b0000));
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        chk("zero_d1", r1(), ex(1'b1, 1'b0, 4'b0000));

        // back-to-back stream then idle
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, va[i], vb[i], vc[i]);
            else drive(1'b0, 4'd0, 4'd0, 1'b0);
            tick();
            if (i < 4) chk($sformatf("b2b_d0_%0d", i), r0(), ex(1'b1, ec[i], es[i]));
            else chk("b2b_d0_idle", r0(), ex(1'b0, 1'b1, 4'b0001));
            if (i > 0) chk($sformatf("b2b_d1_%0d", i - 1), r1(), ex(1'b1, ec[i-1], es[i-1]));
        end
        tick();
        chk("b2b_d1_idle", r1(), ex(1'b0, 1'b1, 4'b0001));

        // asynchronous reset mid-cycle with operands in flight
        drive(1'b1, 4'd5, 4'd5, 1'b0);
        tick();
        drive(1'b1, 4'd6, 4'd6, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_d0", r0(), 8'h00);
        chk("arst_d1", r1(), 8'h00);
`ifdef CLA_4BITS_GROUP_PG_EN
        chk("arst_gpgg", {4'd0, gp0, gg0, gp1, gg1}, 8'h00);
`endif
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_d0", r0(), 8'h00);
        chk("post_rst_d1", r1(), 8'h00);
        drive(1'b1, 4'd2, 4'd3, 1'b0);
        tick();
        chk("post_rst_d0_first", r0(), ex(1'b1, 1'b0, 4'd5));
        chk("post_rst_d1_empty", r1(), 8'h00);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        chk("post_rst_d1_first", r1(), ex(1'b1, 1'b0, 4'd5));

        // exhaustive sweep, streamed back-to-back
        for (int idx = 0; idx <= 512; idx++) begin
            if (idx < 512) begin
                logic [3:0] sa;
                logic [3:0] sb;
                logic       sc;
                sa = idx[8:5];
                sb = idx[4:1];
                sc = idx[0];
                sw_exp[idx] = {1'b0, sa} + {1'b0, sb} + {4'd0, sc};
                drive(1'b1, sa, sb, sc);
            end else begin
                drive(1'b0, 4'd0, 4'd0, 1'b0);
            end
            tick();
            if (idx < 512)
                chk($sformatf("sweep_d0_%0d", idx), r0(),
                    ex(1'b1, sw_exp[idx][4], sw_exp[idx][3:0]));
            if (idx > 0)
                chk($sformatf("sweep_d1_%0d", idx - 1), r1(),
                    ex(1'b1, sw_exp[idx-1][4], sw_exp[idx-1][3:0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_4bits.md
Name: cla_4bits

Overview:
- 4-bit carry-lookahead adder with a registered result stage.
- Computes sum = a + b + cin using explicit generate/propagate lookahead logic, not a ripple chain or a behavioural "+".
- Used as the leaf adder slice inside wider datapath adders.
- A valid qualifier travels alongside the data so upstream and downstream stages can track result timing.

Parameters:
- IN_REG, default 0, input register stage. 0: inputs feed the lookahead logic directly (latency 1). 1: a, b, cin and in_valid are registered first (latency 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a, b, cin this cycle
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- cin  input  1  carry in
- sum  output  4  registered sum bits
- cout  output  1  registered carry out of bit 3
- out_valid  output  1  sum/cout hold a new result this cycle

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Per-bit terms: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Lookahead carries are flattened sum-of-products. Each must be a direct function of g, p and cin, with no dependency on a previous carry:
  - c1 = g0 | p0·cin
  - c2 = g1 | p1·g0 | p1·p0·cin
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·cin
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·cin
- Sum bits: sum[i] = p[i] ^ c[i], with c0 = cin. cout = c4.
- Arithmetic is unsigned, modulo 16; {cout,sum} always equals a+b+cin, covering the range 0..31.
- Register updates:
  - When the input to the output register stage is valid, that stage loads sum, cout and sets out_valid=1.
  - Otherwise sum and cout hold their previous values and out_valid=0.
- Latency: 1 clock from in_valid when IN_REG=0; 2 clocks when IN_REG=1.
- Throughput: one result per clock, with back-to-back in_valid fully supported. No backpressure and no stalls.
- Reset: asserting rst_n low at any time immediately clears sum=0, cout=0, out_valid=0 and any input-stage registers.
- Reset mid-operation: in-flight operands are discarded. The first result after rst_n deasserts comes from the first in_valid sampled after release.
- Boundaries:
  - 0+0+0 -> 0, cout 0.
  - 15+15+1 -> 15, cout 1.
  - Full-propagate case (a^b=1111, cin=1) must produce carry through all four bits in the same cycle.

Optional Feature:
- Macro: CLA_4BITS_GROUP_PG_EN.
- Defined:
  - Adds outputs gp (1 bit) = p3·p2·p1·p0 and gg (1 bit) = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0.
  - Both are registered alongside sum/cout with the same latency and valid behaviour, and both reset to 0.
  - Used for second-level lookahead in wider adders.
- Not defined: these ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset: rst_n=0 asynchronously, mid-cycle -> sum=0000, cout=0, out_valid=0 immediately, without waiting for a clock edge.
- a=1011, b=0010, cin=0, in_valid=1 -> after latency: sum=1101, cout=0, out_valid=1.
- a=1111, b=1111, cin=1 -> sum=1111, cout=1. With the macro defined: gp=0, gg=1.
- a=1010, b=0101, cin=1 (full propagate) -> sum=0000, cout=1. With the macro defined: gp=1, gg=0.
- Back-to-back in_valid over 4 cycles with (3,4,0), (8,8,0), (0,0,1), (7,9,1) -> results 0111/0, 0000/1, 0001/0, 0001/1 on consecutive cycles. Then in_valid=0 -> out_valid=0 and outputs hold 0001/1.
- Exhaustive sweep of all 512 (a,b,cin) combinations for IN_REG=0 and IN_REG=1 -> {cout,sum} == a+b+cin at the stated latency for every combination.
